// File: rtl/dice_roller_if.sv
// Button/display bundle between the debounced roll button and the pip-LED panel.
interface dice_roller_if #(
  parameter int DICE = 2
);
  logic                BTN;
  logic [3*DICE-1:0]   VAL;
  logic [7*DICE-1:0]   LED;
  logic                BUSY;
  logic                DONE;
  logic [7:0]          SUM;

  modport master (output BTN, input VAL, LED, BUSY, DONE, SUM);
  modport slave  (input BTN, output VAL, LED, BUSY, DONE, SUM);
endinterface

// File: rtl/dice_roller.sv
// Multi-die odometer roller with geometric slow-down after release.
// Optional face-sum output enabled by defining DICE_SUM_EN.
module dice_roller #(
  parameter int DICE       = 2,
  parameter int PRESC      = 4,
  parameter int SLOW_STEPS = 4
) (
  input  logic          CLK,
  input  logic          RST,
  dice_roller_if.slave  bus
);

  localparam int unsigned MAXT = PRESC * (1 << (SLOW_STEPS - 1));
  localparam int unsigned CW   = $clog2(MAXT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ROLL, S_SLOW, S_SHOW} state_t;

  state_t              r_state;
  logic [3*DICE-1:0]   r_val;
  logic [7*DICE-1:0]   r_led;
  logic                r_busy;
  logic                r_done;
  logic [CW-1:0]       r_cnt;
  logic [2:0]          r_step;

  logic [3*DICE-1:0]   w_adv;
  logic                w_carry;
  logic [3*DICE-1:0]   w_val_nxt;
  logic [7*DICE-1:0]   w_led_nxt;
  logic [CW-1:0]       w_target;
  logic                w_tick;
  logic                w_last;

  function automatic logic [6:0] f_pips(input logic [2:0] v);
    case (v)
      3'd1:    f_pips = 7'b0001000;
      3'd2:    f_pips = 7'b0100010;
      3'd3:    f_pips = 7'b0101010;
      3'd4:    f_pips = 7'b1100011;
      3'd5:    f_pips = 7'b1101011;
      3'd6:    f_pips = 7'b1110111;
      default: f_pips = 7'b0000000;
    endcase
  endfunction

  assign w_target = CW'(PRESC) << r_step;
  assign w_tick   = (r_state == S_SLOW) && ((r_cnt + 1'b1) == w_target);
  assign w_last   = (r_step == 3'(SLOW_STEPS - 1));

  // Ripple the +1 up the chain; the carry out of the top die is dropped.
  always_comb begin
    w_adv   = r_val;
    w_carry = 1'b1;
    for (int unsigned k = 0; k < DICE; k++) begin
      if (w_carry) begin
        if (r_val[3*k +: 3] == 3'd6) begin
          w_adv[3*k +: 3] = 3'd1;
        end else begin
          w_adv[3*k +: 3] = r_val[3*k +: 3] + 3'd1;
          w_carry         = 1'b0;
        end
      end
    end
  end

  // Next value is shared by VAL, LED and SUM so all three land on the same edge.
  always_comb begin
    w_val_nxt = r_val;
    if (r_state == S_IDLE && bus.BTN) begin
      for (int unsigned k = 0; k < DICE; k++) w_val_nxt[3*k +: 3] = 3'd1;
    end else if (r_state == S_ROLL || w_tick) begin
      w_val_nxt = w_adv;
    end
  end

  always_comb begin
    w_led_nxt = '0;
    for (int unsigned k = 0; k < DICE; k++) w_led_nxt[7*k +: 7] = f_pips(w_val_nxt[3*k +: 3]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_val   <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_step  <= '0;
    end else begin
      r_val  <= w_val_nxt;
      r_led  <= w_led_nxt;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.BTN) begin
            r_state <= S_ROLL;
            r_busy  <= 1'b1;
          end
        end
        S_ROLL: begin
          if (!bus.BTN) begin
            r_state <= S_SLOW;
            r_cnt   <= '0;
            r_step  <= '0;
          end
        end
        S_SLOW: begin
          if (w_tick) begin
            r_cnt  <= '0;
            r_step <= r_step + 3'd1;
            if (w_last) begin
              r_state <= S_SHOW;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (bus.BTN) begin
            r_state <= S_ROLL;
            r_busy  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DICE_SUM_EN
  logic [7:0] w_sum;
  logic [7:0] r_sum;

  always_comb begin
    w_sum = '0;
    for (int unsigned k = 0; k < DICE; k++) w_sum = w_sum + 8'(w_val_nxt[3*k +: 3]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sum <= '0;
    end else if (w_tick && w_last) begin
      r_sum <= w_sum;
    end
  end

  assign bus.SUM = r_sum;
`else
  assign bus.SUM = '0;
`endif

  assign bus.VAL  = r_val;
  assign bus.LED  = r_led;
  assign bus.BUSY = r_busy;
  assign bus.DONE = r_done;

endmodule

// File: doc/dice_roller.md
# dice_roller

Parametrised multi-die roller for the board's pip-LED panel. It holds `DICE` six-sided dice and spins them as an odometer while the roll button is held. After release it slows down geometrically, then freezes and shows the result. Each die drives its own 7-segment pip cluster, using the same pip encoding as the existing single-die decoder. The block sits between the debounced push-button and the LED pins.

## Interface
- `DICE`, 2: number of dice, 1..8.
- `PRESC`, 4: base slow-down interval in clock cycles, ≥1.
- `SLOW_STEPS`, 4: number of decelerating advances after release, 1..8.
- `CLK` input 1: system clock, rising-edge.
- `RST` input 1: asynchronous, active-high reset.
- `BTN` input 1: roll request, level, already debounced and synchronous to `CLK`.
- `VAL` output 3*DICE: die k value in bits [3k+2:3k]; 0 = blank, 1..6 = face.
- `LED` output 7*DICE: die k pip pattern in bits [7k+6:7k].
- `BUSY` output 1: high in ROLL and SLOW.
- `DONE` output 1: one-cycle pulse when the result freezes.
- `SUM` output 8: sum of all faces of the frozen result.

## Operation
- FSM states: IDLE, ROLL, SLOW, SHOW. All outputs are registered.
- Reset (asynchronous): state IDLE, `VAL`=0, `LED`=0, `BUSY`=0, `DONE`=0, `SUM`=0, slow counters 0.
- `LED` is decoded from `VAL` per die (bits 6..0):
  - 0 → 0000000
  - 1 → 0001000
  - 2 → 0100010
  - 3 → 0101010
  - 4 → 1100011
  - 5 → 1101011
  - 6 → 1110111
  - Codes 7 never occur.
- Odometer advance: die 0 steps +1. Going 6→1 carries +1 into die 1, and so on up the chain. The top die wraps 6→1 with the carry discarded.
- IDLE:
  - `BTN`=1 → ROLL, and every die loads 1 on that edge.
  - `BTN`=0 → stay.
- ROLL: every edge performs one odometer advance. On an edge that samples `BTN`=0, the advance still happens and the state moves to SLOW with step index n=0 and the cycle counter cleared.
- SLOW:
  - Count cycles. When the counter reaches PRESC·2^n, perform one advance, clear the counter and increment n.
  - On the advance with n = SLOW_STEPS-1, go to SHOW.
  - `BTN` is ignored in SLOW.
- SHOW:
  - `VAL` is frozen.
  - `BTN`=1 → ROLL, continuing from the current values (no reload to 1).
  - `BTN`=0 → stay.
- `DONE`=1 only in the first cycle of SHOW.
- Changing `DICE` changes only the replication and carry-chain length. No other behaviour changes.

## Timing
- Press latency: the `BTN` high sample in IDLE or SHOW puts `BUSY`=1 and ROLL values on `VAL` in the next cycle.
- Release to freeze: SLOW lasts PRESC·(2^SLOW_STEPS − 1) cycles. `DONE` rises on the edge that enters SHOW.
  - Defaults: 60 cycles.
- `LED` and `VAL` update on the same edge. There is no extra decode latency.
- `SUM` updates on the edge entering SHOW and holds until the next SHOW entry.
- A 1-cycle `BTN` pulse gives exactly one ROLL cycle: the load edge, then an advance on the exit edge.
- `RST` mid-operation, in any state, returns to IDLE immediately with all outputs 0. A pending `DONE` is cancelled.

## Configuration
- `DICE_SUM_EN` defined:
  - `SUM` is computed as the sum of the DICE faces, zero-extended to 8 bits.
  - It is registered on SHOW entry and cleared by reset.
- `DICE_SUM_EN` undefined:
  - The `SUM` port remains but is tied to 0.
  - No adder logic is synthesised.
  - All other behaviour is unchanged.

## Test plan
Bench parameters: DICE=2, PRESC=2, SLOW_STEPS=2, `DICE_SUM_EN` defined.
- Reset: assert `RST` asynchronously mid-cycle → immediately `VAL`=0, `LED`=0, `BUSY`=0, `DONE`=0, `SUM`=0.
- Single-cycle press from IDLE (`BTN` high for one edge) → final result:
  - 6 cycles after the exit edge: SHOW, `DONE` pulses, die0=4, die1=1.
  - `LED`=0001000_1100011, `SUM`=5.
- Carry: press from IDLE and hold for 7 edges (load + 6 advances) → die0 steps 2,3,4,5,6,1 and die1 goes 1→2 on the 6→1 wrap.
- Re-roll from SHOW: after the previous case, press → ROLL continues from the frozen values with no reload. `BTN` toggled during SLOW has no effect on the SLOW duration or the result.
- Reset during SLOW: assert `RST` with `BUSY`=1 → IDLE, no `DONE` pulse. The next press reloads 1,1.
- `DICE_SUM_EN` undefined: repeat the single-cycle press case → identical `VAL`, `LED` and `DONE` behaviour, `SUM` stays 0.
